// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issuer slice: opcode encoding,
// default ALU latency and the response record carried through the FIFO.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_NOT = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_RSV = 3'd7
  } aluop_t;

  localparam int ALU_LAT_DEFAULT = 2;

  // Widest tag the response record can carry; narrower TAG_W is zero-extended.
  localparam int RSP_TAG_W = 4;

  typedef struct packed {
    logic [31:0]          f;
    logic [RSP_TAG_W-1:0] tag;
    logic                 err;
  } alu_rsp_t;

  function automatic logic is_reserved(input aluop_t op);
    return (op == ALU_RSV);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO of alu_rsp_t; head is shown combinationally from
// storage. DEPTH must be a power of two so the pointers wrap naturally.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  alu_rsp_t      push_data,
  input  logic          pop,
  output alu_rsp_t      head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  alu_rsp_t      mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;

  assign empty = (count_r == CW'(0));
  assign full  = (count_r == CW'(DEPTH));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];
  assign pop_s = pop & ~empty;

  // Entry storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  alu_rsp_fifo_chk u_chk (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .full (full)
  );

endmodule

// Overflow guard: the issuer's credit scheme must never push into a full FIFO.
module alu_rsp_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("alu_rsp_fifo: push while full");

endmodule

// File: rtl/alu_issuer.sv
// Initiator front end for the 2-stage ALU: credit-gated issue register, tag
// pipeline aligned to ALU latency, in-order response FIFO and protocol monitor.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = ALU_LAT_DEFAULT,
  parameter int TAG_W   = RSP_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  aluop_t           req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output aluop_t           alu_aluop,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_valid_i,
  input  logic [31:0]      alu_f,
  input  logic             alu_valid_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_f,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + ALU_LAT + 2);
  localparam int FW = $clog2(ALU_LAT + 2);

  typedef enum logic {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic             valid;
    logic             bypass;
    logic [TAG_W-1:0] tag;
  } slot_t;

  state_t        state_r, state_s;
  logic [FW-1:0] flush_cnt_r, flush_cnt_s;
  slot_t         issue_r;
  slot_t         pipe_r [ALU_LAT];
  slot_t         tail_s;
  aluop_t        alu_aluop_r;
  logic [31:0]   alu_a_r, alu_b_r;
  logic          alu_valid_i_r;
  logic          proto_err_r;
  logic          fire_s, push_s, pop_s, proto_hit_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [SW-1:0] inflight_s, used_s;
  alu_rsp_t      push_data_s, head_s;

  // FSM state and flush countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FLUSH;
      flush_cnt_r <= {FW{1'b0}};
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // Hold off issue for ALU_LAT+1 cycles so the unreset ALU drains.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    case (state_r)
      ST_FLUSH: begin
        if (flush_cnt_r == FW'(ALU_LAT)) begin
          state_s = ST_RUN;
        end else begin
          flush_cnt_s = flush_cnt_r + FW'(1);
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_FLUSH;
    endcase
  end

  // Count operations between the issue register and the pipeline tail.
  always_comb begin
    inflight_s = SW'(issue_r.valid);
    for (int i = 0; i < ALU_LAT; i++) begin
      inflight_s = inflight_s + SW'(pipe_r[i].valid);
    end
  end

  assign used_s    = inflight_s + SW'(fifo_count_s);
  assign req_ready = (state_r == ST_RUN) && !fifo_full_s && (used_s < SW'(DEPTH));
  assign fire_s    = req_valid & req_ready;

  // Issue register to the ALU and the tag pipeline shadowing its stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_r       <= {($bits(slot_t)){1'b0}};
      alu_aluop_r   <= ALU_AND;
      alu_a_r       <= 32'd0;
      alu_b_r       <= 32'd0;
      alu_valid_i_r <= 1'b0;
      for (int i = 0; i < ALU_LAT; i++) begin
        pipe_r[i] <= {($bits(slot_t)){1'b0}};
      end
    end else begin
      alu_valid_i_r  <= fire_s && !is_reserved(req_op);
      issue_r.valid  <= fire_s;
      issue_r.bypass <= fire_s && is_reserved(req_op);
      if (fire_s) begin
        issue_r.tag <= req_tag;
        alu_aluop_r <= req_op;
        alu_a_r     <= req_a;
        alu_b_r     <= req_b;
      end
      pipe_r[0] <= issue_r;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tail_s = pipe_r[ALU_LAT-1];
  assign push_s = tail_s.valid;

  // Build the FIFO entry at the tail; reserved ops return zero with err set.
  always_comb begin
    push_data_s.tag = RSP_TAG_W'(tail_s.tag);
    push_data_s.err = tail_s.bypass;
    if (tail_s.bypass) begin
      push_data_s.f = 32'd0;
    end else begin
      push_data_s.f = alu_f;
    end
  end

  assign proto_hit_s = (state_r == ST_RUN) && (alu_valid_o != (tail_s.valid && !tail_s.bypass));

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_r <= 1'b0;
    end else if (proto_hit_s) begin
      proto_err_r <= 1'b1;
    end
  end

  alu_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .push_data(push_data_s),
    .pop      (pop_s),
    .head     (head_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign pop_s       = rsp_valid & rsp_ready;
  assign rsp_valid   = ~fifo_empty_s;
  assign rsp_f       = head_s.f;
  assign rsp_tag     = TAG_W'(head_s.tag);
  assign rsp_err     = head_s.err;
  assign alu_aluop   = alu_aluop_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_valid_i = alu_valid_i_r;
  assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural 2-stage ALU attached;
// table-driven single ops plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_alu_issuer;
  import alu_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  aluop_t           req_op = ALU_AND;
  logic [31:0]      req_a = 32'd0;
  logic [31:0]      req_b = 32'd0;
  logic [TAG_W-1:0] req_tag = 4'd0;
  aluop_t           alu_aluop;
  logic [31:0]      alu_a, alu_b, alu_f;
  logic             alu_valid_i, alu_valid_o;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_f;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err, proto_err;
  logic             inj_valid = 1'b0;
  logic             kill_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issuer #(.DEPTH(8), .ALU_LAT(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_valid_i(alu_valid_i),
    .alu_f(alu_f), .alu_valid_o(alu_valid_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .proto_err(proto_err)
  );

  // Behavioural ALU: two register stages, no reset.
  logic        m_v1 = 1'b0, m_v2 = 1'b0;
  logic [31:0] m_f1 = 32'd0, m_f2 = 32'd0;

  function automatic logic [31:0] alu_fn(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_NOT: return ~a;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SHL: return a << b[4:0];
      ALU_SHR: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_v1 <= alu_valid_i;
    m_f1 <= alu_fn(alu_aluop, alu_a, alu_b);
    m_v2 <= m_v1;
    m_f2 <= m_f1;
  end

  assign alu_f       = m_f2;
  assign alu_valid_o = (m_v2 | inj_valid) & ~kill_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request from a negedge; returns at the negedge after it fired.
  task automatic send(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, output bit ok);
    int n = 0;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int lat);
    lat = 0;
    while (!rsp_valid && lat < bound) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    aluop_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_f;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    bit  ok;
    int  acc;

    vecs[0] = '{ALU_ADD, 32'h0000_0005, 32'h0000_0003, 4'd2,  32'h0000_0008, 1'b0};
    vecs[1] = '{ALU_AND, 32'hF0F0_FF00, 32'h0FF0_0F0F, 4'd1,  32'h00F0_0F00, 1'b0};
    vecs[2] = '{ALU_OR,  32'h1200_0034, 32'h0056_7800, 4'd3,  32'h1256_7834, 1'b0};
    vecs[3] = '{ALU_NOT, 32'h0000_FFFF, 32'h1234_5678, 4'd4,  32'hFFFF_0000, 1'b0};
    vecs[4] = '{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 4'd6,  32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{ALU_SHL, 32'h0000_0003, 32'h0000_0004, 4'd7,  32'h0000_0030, 1'b0};
    vecs[6] = '{ALU_SHR, 32'h8000_0000, 32'h0000_001F, 4'd8,  32'h0000_0001, 1'b0};
    vecs[7] = '{ALU_RSV, 32'hDEAD_BEEF, 32'hBEEF_DEAD, 4'd9,  32'h0000_0000, 1'b1};
    vecs[8] = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 4'd15, 32'h0000_0000, 1'b0};

    // Reset state and flush window.
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_alu_valid_i", alu_valid_i, 1'b0);
    check("rst_alu_aluop", 32'(alu_aluop), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_ready_1", req_ready, 1'b0);
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    check("flush_ready_2", req_ready, 1'b0);
    @(negedge clk);
    check("flush_ready_3", req_ready, 1'b1);
    check("flush_stray_proto", proto_err, 1'b0);

    // Table of single operations.
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, ok);
      check($sformatf("v%0d_fire", i), ok, 1'b1);
      wait_rsp(10, lat);
      check($sformatf("v%0d_latency", i), lat, 3);
      check($sformatf("v%0d_f", i), rsp_f, vecs[i].exp_f);
      check($sformatf("v%0d_tag", i), rsp_tag, vecs[i].tag);
      check($sformatf("v%0d_err", i), rsp_err, vecs[i].exp_err);
      @(negedge clk);
      check($sformatf("v%0d_popped", i), rsp_valid, 1'b0);
    end

    // Back-to-back: SUB 1-2, SHL 1<<31, NOT 0.
    req_valid = 1'b1;
    req_op = ALU_SUB; req_a = 32'd1; req_b = 32'd2; req_tag = 4'd0;
    check("b2b_ready0", req_ready, 1'b1);
    @(negedge clk);
    req_op = ALU_SHL; req_a = 32'd1; req_b = 32'd31; req_tag = 4'd1;
    check("b2b_ready1", req_ready, 1'b1);
    @(negedge clk);
    req_op = ALU_NOT; req_a = 32'd0; req_b = 32'd0; req_tag = 4'd2;
    check("b2b_ready2", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(10, lat);
    check("b2b_valid0", rsp_valid, 1'b1);
    check("b2b_f0", rsp_f, 32'hFFFF_FFFF);
    check("b2b_tag0", rsp_tag, 4'd0);
    @(negedge clk);
    check("b2b_valid1", rsp_valid, 1'b1);
    check("b2b_f1", rsp_f, 32'h8000_0000);
    check("b2b_tag1", rsp_tag, 4'd1);
    @(negedge clk);
    check("b2b_valid2", rsp_valid, 1'b1);
    check("b2b_f2", rsp_f, 32'hFFFF_FFFF);
    check("b2b_tag2", rsp_tag, 4'd2);
    @(negedge clk);
    check("b2b_empty", rsp_valid, 1'b0);

    // Reserved op between two ADDs.
    req_valid = 1'b1;
    req_op = ALU_ADD; req_a = 32'd10; req_b = 32'd1; req_tag = 4'd3;
    @(negedge clk);
    check("rsv_valid_i_add0", alu_valid_i, 1'b1);
    req_op = ALU_RSV; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_tag = 4'd5;
    @(negedge clk);
    check("rsv_valid_i_rsv", alu_valid_i, 1'b0);
    req_op = ALU_ADD; req_a = 32'd20; req_b = 32'd2; req_tag = 4'd6;
    @(negedge clk);
    req_valid = 1'b0;
    check("rsv_valid_i_add1", alu_valid_i, 1'b1);
    wait_rsp(10, lat);
    check("rsv_r0_f", rsp_f, 32'd11);
    check("rsv_r0_tag", rsp_tag, 4'd3);
    check("rsv_r0_err", rsp_err, 1'b0);
    @(negedge clk);
    check("rsv_r1_valid", rsp_valid, 1'b1);
    check("rsv_r1_f", rsp_f, 32'd0);
    check("rsv_r1_tag", rsp_tag, 4'd5);
    check("rsv_r1_err", rsp_err, 1'b1);
    @(negedge clk);
    check("rsv_r2_f", rsp_f, 32'd22);
    check("rsv_r2_tag", rsp_tag, 4'd6);
    check("rsv_r2_err", rsp_err, 1'b0);
    check("rsv_proto", proto_err, 1'b0);
    @(negedge clk);

    // Backpressure: 20 offered, only DEPTH accepted.
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = 1'b1; req_op = ALU_ADD;
      req_a = 32'(acc); req_b = 32'd1; req_tag = 4'(acc);
      ok = req_ready;
      @(negedge clk);
      if (ok) acc++;
    end
    req_valid = 1'b0;
    check("fill_accepted", acc, 8);
    check("fill_ready_low", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), rsp_valid, 1'b1);
      check($sformatf("drain%0d_tag", i), rsp_tag, 4'(i));
      check($sformatf("drain%0d_f", i), rsp_f, 32'(i + 1));
      @(negedge clk);
    end
    check("drain_empty", rsp_valid, 1'b0);
    check("drain_ready_back", req_ready, 1'b1);

    // Dropped valid_o sets the sticky protocol error.
    send(ALU_ADD, 32'd5, 32'd3, 4'd7, ok);
    @(negedge clk);
    @(negedge clk);
    check("drop_proto_before", proto_err, 1'b0);
    kill_valid = 1'b1;
    @(negedge clk);
    kill_valid = 1'b0;
    check("drop_proto_set", proto_err, 1'b1);
    check("drop_rsp_valid", rsp_valid, 1'b1);
    check("drop_rsp_f", rsp_f, 32'd8);
    check("drop_rsp_tag", rsp_tag, 4'd7);
    repeat (5) @(negedge clk);
    check("drop_proto_sticky", proto_err, 1'b1);

    // Mid-stream reset with buffered and in-flight work.
    rsp_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, 4'd1, ok);
    send(ALU_ADD, 32'd2, 32'd2, 4'd2, ok);
    repeat (5) @(negedge clk);
    check("mid_buffered", rsp_valid, 1'b1);
    send(ALU_OR, 32'd4, 32'd4, 4'd3, ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_proto_clr", proto_err, 1'b0);
    check("mid_req_ready", req_ready, 1'b0);
    check("mid_valid_i", alu_valid_i, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_proto", proto_err, 1'b0);
    check("post_rst_rsp", rsp_valid, 1'b0);
    check("post_rst_ready", req_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Initiator-side front end for the 2-stage pipelined ALU.
- Accepts tagged operation requests over a valid/ready interface and drives the ALU's aluop/a/b/valid_i inputs from a register stage.
- Tracks in-flight operations against the ALU's fixed latency, captures f/valid_o into a response FIFO, and returns tagged results in order with backpressure.
- The ALU has no stall input, so the issuer reserves response space by credit before issuing.

Parameters:
- DEPTH, 8: response FIFO entries; must be ≥ ALU_LAT+3 for 1 op/cycle throughput.
- ALU_LAT, 2: clock edges from ALU sampling valid_i=1 to valid_o=1 being visible.
- TAG_W, 4: request/response tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  3  aluop_t
- req_a  in  32  operand a
- req_b  in  32  operand b
- req_tag  in  TAG_W  request tag
- alu_aluop  out  3  to ALU aluop
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_valid_i  out  1  to ALU valid_i
- alu_f  in  32  from ALU f
- alu_valid_o  in  1  from ALU valid_o
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_f  out  32  result
- rsp_tag  out  TAG_W  tag of the originating request
- rsp_err  out  1  response is for a reserved op (7); rsp_f=0
- proto_err  out  1  sticky ALU protocol mismatch

Behaviour:
- Reset (async assert, sync release): alu_valid_i=0, alu_aluop/a/b=0, FIFO empty, rsp_valid=0, proto_err=0, in-flight pipeline cleared.
- Post-reset flush: the ALU has no reset. For ALU_LAT+1 cycles after rst_n rises, FLUSH state holds req_ready=0 and ignores alu_valid_o. Then enter RUN.
- States: FLUSH → RUN only. Reset from any state returns to FLUSH. A mid-operation reset drops all in-flight and buffered responses.
- Credit rule: req_ready = RUN && (fifo_count + inflight) < DEPTH.
  - Both operands are registered values. There is no combinational path from rsp_ready or req_valid to req_ready.
  - inflight counts valid entries in the tag pipeline: issue register plus ALU_LAT stages, range 0..ALU_LAT+1.
- Issue: on fire, capture op/a/b into the issue register. In the next cycle, alu_valid_i=1 and alu_* hold the captured values.
  - Exception: op==7 (reserved) is issued with alu_valid_i=0 and marked bypass.
  - With no fire, alu_valid_i=0 next cycle.
- Tag pipeline: {valid, bypass, tag} shifts each cycle in lockstep with the ALU, ALU_LAT stages after the issue register.
- Capture: at the pipeline tail, a valid non-bypass entry pushes {alu_f, tag, err=0} into the FIFO; a bypass entry pushes {0, tag, err=1}.
  - Responses are strictly in request order.
  - Latency from req fire edge to rsp_valid=1: ALU_LAT+1 edges (3 by default).
- Protocol check (RUN only): set proto_err, cleared only by reset, if either occurs:
  - alu_valid_o=1 while the tail entry is invalid or bypass;
  - alu_valid_o=0 while the tail entry is valid non-bypass (that entry is still pushed with the sampled alu_f).
- FIFO: rsp_* show the head entry combinationally from FIFO storage.
  - Push and pop may occur on the same edge; count is unchanged.
  - Push never meets a full FIFO; the credit rule guarantees this. Implementation asserts it.
  - Pointers wrap modulo DEPTH. DEPTH must be a power of two.
- Throughput: 1 op/cycle sustained when rsp_ready=1 and DEPTH ≥ ALU_LAT+3. With rsp_ready=0, at most DEPTH ops are accepted, then req_ready=0.

Decomposition:
- alu_pkg:
  - aluop_t enum: AND=0, OR=1, NOT=2, ADD=3, SUB=4, SHL=5, SHR=6; 7 reserved.
  - ALU_LAT_DEFAULT=2.
  - alu_rsp_t struct {f, tag, err}.
- Sub-module alu_rsp_fifo: parameterised synchronous FIFO of alu_rsp_t with push/pop/count/full/empty and async active-low reset.

Test Plan:
- Reset release → req_ready=0 for 3 cycles, then 1. A stray alu_valid_o=1 pulse during FLUSH leaves proto_err=0.
- Single ADD a=32'h0000_0005, b=32'h0000_0003, tag=2 with a real ALU attached → rsp_valid 3 cycles after fire, rsp_f=8, rsp_tag=2, rsp_err=0.
- Back-to-back SUB 1-2, SHL 1<<31, NOT 0 (tags 0,1,2), rsp_ready=1 → one response per cycle, in order: FFFF_FFFF, 8000_0000, FFFF_FFFF.
- rsp_ready=0 with 20 ADD requests offered → exactly 8 accepted, req_ready=0 afterward. Then rsp_ready=1 drains 8 in tag order and acceptance resumes.
- op=7 tag=5 between two ADDs → alu_valid_i stays 0 for it; response {f=0, tag=5, err=1} sits between the two ADD results.
- ALU model drops valid_o for one issued op → proto_err=1 at that tail cycle and stays 1 until rst_n=0. Asserting rst_n mid-stream empties FIFO and sets rsp_valid=0 immediately.
